hex_onehot_encoder: RTL and testbench

//  Reverse direction of the 4-to-16 binary-to-hex one-hot decoder.

---
 rtl/hex_onehot_encoder_if.sv | 25 ++
 rtl/hex_onehot_encoder.sv | 95 +++++++++
 tb/tb_hex_onehot_encoder.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/hex_onehot_encoder_if.sv
// Handshake bundle for the hex one-hot encoder: request vector in, serialized indices out.
interface hex_onehot_encoder_if #(
   parameter int WIDTH = 16,
   parameter int IDX_W = $clog2(WIDTH)
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_vec;
   logic             out_valid;
   logic             out_ready;
   logic [IDX_W-1:0] out_idx;
   logic             out_last;
   logic             multi_hot;
   logic             zero_err;

   modport master (
      output in_valid, in_vec, out_ready,
      input  in_ready, out_valid, out_idx, out_last, multi_hot, zero_err
   );

   modport slave (
      input  in_valid, in_vec, out_ready,
      output in_ready, out_valid, out_idx, out_last, multi_hot, zero_err
   );
endinterface

// File: rtl/hex_onehot_encoder.sv
// Serial priority encoder: emits the index of every set bit of an accepted vector,
// lowest first, one per output handshake.
//
//  state    | meaning
//  ---------+--------------------------------------------------------
//  ST_IDLE  | in_ready=1, waiting for a vector
//  ST_DRAIN | out_valid=1, presenting lowest pending index
module hex_onehot_encoder #(
   parameter int WIDTH = 16,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   hex_onehot_encoder_if.slave   bus
);

   typedef enum logic {ST_IDLE, ST_DRAIN} state_t;

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state_q,     state_d;
   logic [WIDTH-1:0] pending_q,   pending_d;
   logic             multi_hot_q, multi_hot_d;
   logic             zero_err_q,  zero_err_d;
   logic [IDX_W-1:0] out_idx_q,   out_idx_d;
   logic             out_last_q,  out_last_d;

   always_comb begin
      state_d     = state_q;
      pending_d   = pending_q;
      multi_hot_d = multi_hot_q;
      zero_err_d  = 1'b0;
      out_idx_d   = '0;
      out_last_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               if (bus.in_vec != '0) begin
                  pending_d   = bus.in_vec;
                  multi_hot_d = (bus.in_vec & (bus.in_vec - ONE)) != '0;
                  state_d     = ST_DRAIN;
               end else begin
                  zero_err_d  = 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (bus.out_ready) begin
               pending_d = pending_q & (pending_q - ONE);
               if (out_last_q) begin
                  pending_d   = '0;
                  multi_hot_d = 1'b0;
                  state_d     = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Index/last are registered from next-state pending so they are stable for the whole cycle.
      if (state_d == ST_DRAIN) begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pending_d[i]) out_idx_d = IDX_W'(i);
         end
         out_last_d = (pending_d & (pending_d - ONE)) == '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         pending_q   <= '0;
         multi_hot_q <= 1'b0;
         zero_err_q  <= 1'b0;
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         multi_hot_q <= multi_hot_d;
         zero_err_q  <= zero_err_d;
         out_idx_q   <= out_idx_d;
         out_last_q  <= out_last_d;
      end
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = (state_q == ST_DRAIN);
   assign bus.out_idx   = out_idx_q;
   assign bus.out_last  = out_last_q;
   assign bus.multi_hot = multi_hot_q;
   assign bus.zero_err  = zero_err_q;

endmodule

// File: tb/tb_hex_onehot_encoder.sv
// Directed and randomized bench for hex_onehot_encoder against a set-bit-list model.
module tb_hex_onehot_encoder;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   hex_onehot_encoder_if #(.WIDTH(16), .IDX_W(4)) bus ();

   hex_onehot_encoder #(.WIDTH(16), .IDX_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input int idx, input bit last, input bit multi);
      chk("out_valid", 32'(bus.out_valid), 1);
      chk("in_ready_busy", 32'(bus.in_ready), 0);
      chk("out_idx", 32'(bus.out_idx), 32'(idx));
      chk("out_last", 32'(bus.out_last), 32'(last));
      chk("multi_hot", 32'(bus.multi_hot), 32'(multi));
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 1);
      chk({tag, "_out_idx"}, 32'(bus.out_idx), 0);
      chk({tag, "_multi_hot"}, 32'(bus.multi_hot), 0);
      chk({tag, "_out_last"}, 32'(bus.out_last), 0);
   endtask

   // Expected output list is simply the ascending positions of the set bits.
   task automatic send(input logic [15:0] vec, input int stall_first, input bit rnd);
      int q[$];
      int n;
      int k;
      for (int i = 0; i < 16; i++) if (vec[i]) q.push_back(i);
      n = q.size();
      chk("in_ready_pre", 32'(bus.in_ready), 1);
      bus.in_valid = 1'b1;
      bus.in_vec   = vec;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_vec   = 16'($urandom);
      if (n == 0) begin
         chk("zero_err_pulse", 32'(bus.zero_err), 1);
         chk("zero_out_valid", 32'(bus.out_valid), 0);
         chk("zero_in_ready", 32'(bus.in_ready), 1);
         @(negedge clk);
         chk("zero_err_clear", 32'(bus.zero_err), 0);
         chk("zero_out_valid2", 32'(bus.out_valid), 0);
         return;
      end
      for (int j = 0; j < n; j++) begin
         k = (j == 0) ? stall_first : (rnd ? int'($urandom_range(0, 2)) : 0);
         bus.out_ready = (k == 0);
         chk_out(q[j], j == n - 1, n > 1);
         chk("zero_err_busy", 32'(bus.zero_err), 0);
         repeat (k) begin
            @(negedge clk);
            bus.in_vec = 16'($urandom);
            chk_out(q[j], j == n - 1, n > 1);
         end
         bus.out_ready = 1'b1;
         @(negedge clk);
      end
      chk_idle("post_drain");
   endtask

   initial begin
      logic [15:0] v;
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_vec    = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk_idle("reset");
      chk("reset_zero_err", 32'(bus.zero_err), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Round-trip of every decoder output, back to back.
      for (int x = 0; x < 16; x++) begin
         v = 16'(1) << x;
         send(v, 0, 1'b0);
      end

      send(16'hA005, 0, 1'b0);
      send(16'h0110, 3, 1'b0);
      send(16'h0000, 0, 1'b0);
      send(16'hFFFF, 0, 1'b0);
      send(16'h0001, 2, 1'b1);
      send(16'h8000, 1, 1'b1);

      // Asynchronous reset in the middle of an all-ones drain.
      bus.in_valid = 1'b1;
      bus.in_vec   = 16'hFFFF;
      @(negedge clk);
      bus.in_valid = 1'b0;
      for (int j = 0; j < 5; j++) begin
         chk_out(j, 1'b0, 1'b1);
         @(negedge clk);
      end
      chk_out(5, 1'b0, 1'b1);
      #2 rst_n = 1'b0;
      #1 chk_idle("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(16'h8000, 0, 1'b0);

      for (int r = 0; r < 60; r++) begin
         case ($urandom_range(0, 3))
            0:       v = '0;
            1:       v = 16'(1) << $urandom_range(0, 15);
            default: v = 16'($urandom);
         endcase
         send(v, int'($urandom_range(0, 2)), 1'b1);
         bus.out_ready = 1'($urandom);
         repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            chk_idle("idle_gap");
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
